// File: rtl/multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control FSM for the RV32I core. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. The FSM runs the instruction and
// data memory request/ready handshakes. It also qualifies the decoder's
// combinational RegWr/MemWr so that architectural state changes exactly once
// per retired instruction.
//
// Optional feature (macro SEQ_PERF_CNT_EN):
//   When defined, adds the cycle_cnt / instret_cnt performance counters.
//   When undefined, those ports and their logic are absent.
//
// Parameters:
//   XLEN      instruction / IR / counter width (fixed at 32)
//   RESET_IR  IR value after reset (NOP = ADDI x0,x0,0)
//
// Ports:
//   clk          in   core clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   run          in   1 = keep fetching, 0 = park in IDLE at a boundary
//   imem_req     out  instruction fetch request (held until imem_ready)
//   imem_ready   in   instr_in valid this cycle
//   instr_in     in   fetched instruction word
//   ir           out  latched instruction register (feeds the decoder)
//   regwr_dec    in   decoder RegWr for the current ir
//   memwr_dec    in   decoder MemWr for the current ir
//   dmem_req     out  data memory request (only in MEM)
//   dmem_we      out  data memory write enable (MEM and memwr_dec)
//   dmem_ready   in   data access complete / load data valid
//   rf_we        out  qualified register-file write strobe (WB and regwr_dec)
//   pc_we        out  one-cycle PC update strobe in WB
//   ir_we        out  IR load strobe (FETCH and imem_ready)
//   halted       out  sticky: ECALL/EBREAK or illegal opcode reached
//   illegal      out  sticky: halt cause was an illegal opcode
//   state        out  current FSM state (debug)
//   cycle_cnt    out  [SEQ_PERF_CNT_EN] active (non-IDLE/HALT) cycles
//   instret_cnt  out  [SEQ_PERF_CNT_EN] retired instructions
// ----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_IR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] ir,
    input  logic            regwr_dec,
    input  logic            memwr_dec,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            rf_we,
    output logic            pc_we,
    output logic            ir_we,
    output logic            halted,
    output logic            illegal,
`ifdef SEQ_PERF_CNT_EN
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt,
`endif
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    // RV32I base opcodes recognised by the classifier
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t          r_state;
    logic [XLEN-1:0] r_ir;
    logic            r_halted;
    logic            r_illegal;

    // One-hot phase flags, registered from the next state so the Moore
    // strobes come straight from flops and drop with the async reset.
    logic            r_fetch;
    logic            r_mem;
    logic            r_wb;

    state_t          w_next_state;
    logic [6:0]      w_opcode;
    logic            w_is_legal;
    logic            w_is_system;
    logic            w_is_mem;
    logic            w_ir_load;
    logic            w_set_halt;
    logic            w_set_illegal;

    // ------------------------------------------------------------------
    // Opcode classification of the latched instruction
    // ------------------------------------------------------------------
    always_comb begin
        w_opcode    = r_ir[6:0];
        w_is_legal  = 1'b0;
        w_is_system = 1'b0;
        w_is_mem    = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC, OP_REG, OP_IMM,
            OP_JAL, OP_JALR, OP_BRANCH, OP_FENCE: begin
                w_is_legal = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
                w_is_legal = 1'b1;
                w_is_mem   = 1'b1;
            end
            OP_SYSTEM: begin
                w_is_legal  = 1'b1;
                w_is_system = 1'b1;
            end
            default: begin
                w_is_legal = 1'b0;
            end
        endcase
    end

    // IR capture happens only in the FETCH ready cycle; a stray imem_ready
    // in any other state is ignored.
    assign w_ir_load = (r_state == S_FETCH) && imem_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_set_halt    = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                // run is not consulted here: a started fetch always completes
                if (imem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_is_legal) begin
                    w_next_state  = S_HALT;
                    w_set_halt    = 1'b1;
                    w_set_illegal = 1'b1;
                end else if (w_is_system) begin
                    w_next_state = S_HALT;
                    w_set_halt   = 1'b1;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = w_is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    w_next_state = S_WB;
                end
            end
            S_WB: begin
                // the only place where run=0 can park the core
                w_next_state = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                // unused encoding falls back to IDLE
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, IR, sticky flags and phase flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ir      <= RESET_IR;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_fetch   <= 1'b0;
            r_mem     <= 1'b0;
            r_wb      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_ir_load) begin
                r_ir <= instr_in;
            end
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            r_fetch <= (w_next_state == S_FETCH);
            r_mem   <= (w_next_state == S_MEM);
            r_wb    <= (w_next_state == S_WB);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [XLEN-1:0] r_cycle_cnt;
    logic [XLEN-1:0] r_instret_cnt;

    // Free-running counters; natural wrap at 2^XLEN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_state != S_HALT)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (r_state == S_WB) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

    // ------------------------------------------------------------------
    // Outputs. dmem_we / rf_we gate the decoder strobes with the phase
    // so stores and register writes happen only once per instruction.
    // ------------------------------------------------------------------
    assign imem_req = r_fetch;
    assign ir_we    = r_fetch & imem_ready;
    assign dmem_req = r_mem;
    assign dmem_we  = r_mem & memwr_dec;
    assign rf_we    = r_wb & regwr_dec;
    assign pc_we    = r_wb;
    assign ir       = r_ir;
    assign halted   = r_halted;
    assign illegal  = r_illegal;
    assign state    = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Randomised bench for multicycle_sequencer. A driver process plays the
// instruction and data memories with random wait states and random run
// drops. When it hands out an instruction, it pushes the expected
// retirement/halt profile into a scoreboard queue. A monitor process pops
// and compares whenever the DUT retires (pc_we) or halts. A main process
// sequences episodes: reset, run, then halt or an async reset mid-MEM.
// ----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] instr_in = 32'h0;
    logic        regwr_dec;
    logic        memwr_dec;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, rf_we, pc_we, ir_we, halted, illegal;
    logic [31:0] ir;
    logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .instr_in   (instr_in),
        .ir         (ir),
        .regwr_dec  (regwr_dec),
        .memwr_dec  (memwr_dec),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .rf_we      (rf_we),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .halted     (halted),
        .illegal    (illegal),
`ifdef SEQ_PERF_CNT_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .state      (state)
    );

    always #5 clk = ~clk;

    // Stand-in for the instruction decoder's write strobes
    always_comb begin
        regwr_dec = ir[6:0] inside {7'b0110111, 7'b0010111, 7'b0110011,
                                    7'b0010011, 7'b1101111, 7'b1100111,
                                    7'b0000011};
        memwr_dec = (ir[6:0] == 7'b0100011);
    end

    typedef struct {
        bit          isHalt;
        bit          isIllegal;
        int          latency;
        int          dmemCycles;
        int          dmemWeCycles;
        int          rfCycles;
        logic [31:0] instr;
    } exp_t;

    exp_t sbQ[$];
    int   total = 0;
    int   bad = 0;
    int   retired = 0;
    bit   runRandom = 0;
    bit   runLevel = 0;
    int   haltMode = 0;
    bit   haltIssued = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit isLegalOp(input logic [6:0] op);
        return op inside {7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011,
                          7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                          7'b0100011, 7'b0001111, 7'b1110011};
    endfunction

    // Reference model: cycle profile of one instruction from its opcode and
    // the memory wait states the driver will apply to it.
    function automatic exp_t refModel(input logic [31:0] instr, input int iw, input int dw);
        exp_t e;
        logic [6:0] op;
        bit isMem, writesRf;
        op = instr[6:0];
        isMem    = (op == 7'b0000011) || (op == 7'b0100011);
        writesRf = op inside {7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011,
                              7'b1101111, 7'b1100111, 7'b0000011};
        e.instr     = instr;
        e.isIllegal = !isLegalOp(op);
        e.isHalt    = e.isIllegal || (op == 7'b1110011);
        if (e.isHalt) begin
            // fetch cycles + decode + first halted cycle
            e.latency      = (1 + iw) + 1 + 1;
            e.dmemCycles   = 0;
            e.dmemWeCycles = 0;
            e.rfCycles     = 0;
        end else begin
            e.dmemCycles   = isMem ? (1 + dw) : 0;
            e.latency      = (1 + iw) + 1 + 1 + e.dmemCycles + 1;
            e.dmemWeCycles = (op == 7'b0100011) ? e.dmemCycles : 0;
            e.rfCycles     = writesRf ? 1 : 0;
        end
        return e;
    endfunction

    // mode 0: normal instruction, 1: illegal opcode, 2: ECALL/EBREAK
    function automatic logic [31:0] genInstr(input int mode);
        logic [6:0]  ops [10];
        logic [31:0] r;
        logic [6:0]  op;
        int          k;
        ops = '{7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011, 7'b1101111,
                7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0001111};
        r = $urandom;
        if (mode == 1) begin
            if ($urandom_range(0, 3) == 0) return 32'h0000007F;
            do op = 7'($urandom_range(0, 127)); while (isLegalOp(op));
            return {r[31:7], op};
        end
        if (mode == 2) begin
            k = $urandom_range(0, 2);
            if (k == 0) return 32'h00000073;
            if (k == 1) return 32'h00100073;
            return {r[31:7], 7'b1110011};
        end
        k = $urandom_range(0, 12);
        if (k == 10) return 32'h00500093;
        if (k == 11) return 32'h0000A103;
        if (k == 12) return 32'h0020A223;
        return {r[31:7], ops[k]};
    endfunction

    // ------------------------------------------------------------------
    // Driver: run control plus instruction and data memory responders
    // ------------------------------------------------------------------
    initial begin : driver
        bit          prevReq;
        bit          prevDreq;
        int          iw, dw, curDw, mode;
        logic [31:0] curInstr;
        prevReq = 0; prevDreq = 0; iw = 0; dw = 0; curDw = 0; curInstr = 0;
        forever begin
            @(posedge clk);
            #1;
            run = runRandom ? ($urandom_range(0, 7) != 0) : runLevel;
            if (!rst_n) begin
                imem_ready = 0;
                dmem_ready = 0;
                prevReq    = 0;
                prevDreq   = 0;
                haltIssued = 0;
                continue;
            end
            if (imem_req) begin
                if (!prevReq) begin
                    mode = 0;
                    if (haltMode != 0 && !haltIssued) begin
                        mode       = haltMode;
                        haltIssued = 1;
                    end
                    curInstr = genInstr(mode);
                    iw       = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
                    curDw    = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
                    sbQ.push_back(refModel(curInstr, iw, curDw));
                end
                if (iw == 0) begin
                    imem_ready = 1;
                    instr_in   = curInstr;
                end else begin
                    imem_ready = 0;
                    instr_in   = $urandom;
                    iw--;
                end
            end else begin
                // stray ready pulses with garbage data must be ignored
                imem_ready = ($urandom_range(0, 3) == 0);
                instr_in   = $urandom;
            end
            prevReq = imem_req;
            if (dmem_req) begin
                if (!prevDreq) dw = curDw;
                if (dw == 0) begin
                    dmem_ready = 1;
                end else begin
                    dmem_ready = 0;
                    dw--;
                end
            end else begin
                dmem_ready = ($urandom_range(0, 3) == 0);
            end
            prevDreq = dmem_req;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: accumulates per-instruction strobe counts and compares at
    // retirement or halt against the scoreboard.
    // ------------------------------------------------------------------
    initial begin : monitor
        bit         inInstr, pendValid, prevHalted;
        logic [2:0] pendState;
        int         cnt, dCnt, dweCnt, rfCnt, irweCnt;
        exp_t       e;
        inInstr = 0; pendValid = 0; prevHalted = 0; pendState = 0;
        cnt = 0; dCnt = 0; dweCnt = 0; rfCnt = 0; irweCnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbQ.delete();
                inInstr = 0; pendValid = 0; prevHalted = 0; retired = 0;
                continue;
            end
            if (pendValid) begin
                checkOutput("parkOrResume", 32'(state), 32'(pendState));
                pendValid = 0;
            end
            if (!inInstr && imem_req) begin
                inInstr = 1; cnt = 0; dCnt = 0; dweCnt = 0; rfCnt = 0; irweCnt = 0;
            end
            if (inInstr) begin
                cnt++;
                dCnt    += int'(dmem_req);
                dweCnt  += int'(dmem_we);
                rfCnt   += int'(rf_we);
                irweCnt += int'(ir_we);
            end else begin
                checkOutput("idleStrobes", {27'b0, dmem_req, dmem_we, rf_we, pc_we, ir_we}, 32'h0);
            end
            if (state == 3'd0) begin
                pendValid = 1;
                pendState = run ? 3'd1 : 3'd0;
            end
            if (pc_we && inInstr) begin
                retired++;
                checkOutput("sbHasEntry", 32'(sbQ.size() != 0), 32'h1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    checkOutput("retireNotHalt", 32'(e.isHalt), 32'h0);
                    checkOutput("latency", 32'(cnt), 32'(e.latency));
                    checkOutput("ir", ir, e.instr);
                    checkOutput("irWeCycles", 32'(irweCnt), 32'h1);
                    checkOutput("dmemReqCycles", 32'(dCnt), 32'(e.dmemCycles));
                    checkOutput("dmemWeCycles", 32'(dweCnt), 32'(e.dmemWeCycles));
                    checkOutput("rfWeCycles", 32'(rfCnt), 32'(e.rfCycles));
                    checkOutput("rfWeWithPcWe", 32'(rf_we), 32'(e.rfCycles));
                end
`ifdef SEQ_PERF_CNT_EN
                checkOutput("instretCnt", instret_cnt, 32'(retired - 1));
`endif
                pendValid = 1;
                pendState = run ? 3'd1 : 3'd0;
                inInstr   = 0;
            end
            if (halted && !prevHalted) begin
                checkOutput("sbHasHaltEntry", 32'(sbQ.size() != 0), 32'h1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    checkOutput("haltKind", 32'(e.isHalt), 32'h1);
                    checkOutput("illegalFlag", 32'(illegal), 32'(e.isIllegal));
                    checkOutput("haltLatency", 32'(cnt), 32'(e.latency));
                    checkOutput("haltIr", ir, e.instr);
                    checkOutput("haltNoWrites", 32'(dCnt + rfCnt), 32'h0);
                end
                inInstr = 0;
            end
            prevHalted = halted;
        end
    end

    // Reset pulse and run-mode setup for an episode
    task automatic applyStimulus(input bit randomRun, input int nextHalt);
        haltMode  = 0;
        runRandom = 0;
        runLevel  = 0;
        rst_n     = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        checkOutput("resetState", 32'(state), 32'h0);
        checkOutput("resetIr", ir, 32'h00000013);
        checkOutput("resetFlags", {30'b0, halted, illegal}, 32'h0);
        checkOutput("resetStrobes", {26'b0, imem_req, dmem_req, dmem_we, rf_we, pc_we, ir_we}, 32'h0);
`ifdef SEQ_PERF_CNT_EN
        checkOutput("resetCycleCnt", cycle_cnt, 32'h0);
        checkOutput("resetInstretCnt", instret_cnt, 32'h0);
`endif
        runRandom = randomRun;
        runLevel  = 1;
        haltMode  = 0;
        if (nextHalt < 0) haltMode = 0;
    endtask

    task automatic waitRetired(input int target);
        int cyc;
        cyc = 0;
        while (retired < target && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput("retireProgress", 32'(retired >= target), 32'h1);
    endtask

    initial begin : mainSeq
        int  kind, cyc;
        bit  found;
        for (int ep = 0; ep < 6; ep++) begin
            kind = ep % 3;
            applyStimulus(ep % 2 == 1, kind);
            if (ep % 2 == 0) begin
                // park: drop run, the current instruction completes, then IDLE
                waitRetired(10);
                runLevel = 0;
                repeat (16) @(negedge clk);
                checkOutput("parkedIdle", 32'(state), 32'h0);
                runLevel = 1;
            end
            waitRetired(25);
            if (kind == 2) begin
                found = 0;
                cyc = 0;
                while (!found && cyc < 5000) begin
                    @(negedge clk);
                    found = dmem_req;
                    cyc++;
                end
                checkOutput("sawDmemReq", 32'(found), 32'h1);
                #2 rst_n = 0;
                #1;
                checkOutput("asyncResetDmemReq", 32'(dmem_req), 32'h0);
                checkOutput("asyncResetState", 32'(state), 32'h0);
                checkOutput("asyncResetIr", ir, 32'h00000013);
`ifdef SEQ_PERF_CNT_EN
                checkOutput("asyncResetCycleCnt", cycle_cnt, 32'h0);
                checkOutput("asyncResetInstretCnt", instret_cnt, 32'h0);
`endif
            end else begin
                haltMode = (kind == 1) ? 1 : 2;
                cyc = 0;
                while (!halted && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                end
                checkOutput("reachedHalt", 32'(halted), 32'h1);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    checkOutput("haltQuiet",
                                {22'b0, imem_req, dmem_req, dmem_we, rf_we, pc_we, ir_we, halted, state},
                                {22'b0, 6'b0, 1'b1, 3'd6});
                end
                checkOutput("haltCause", 32'(illegal), 32'(kind == 1));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Runs the instruction- and data-memory request/ready handshakes.
- Gates the decoder's combinational RegWr/MemWr strobes so architectural state changes exactly once per instruction.
- Sits between the instruction decoder, register file, PC register and memory ports.

Parameters:
- RESET_IR, 32'h00000013, IR value loaded at reset (ADDI x0,x0,0 / NOP).
- XLEN, 32, instruction/IR width. Fixed at 32; kept as a parameter for the counter width.

Ports:
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = fetch next instruction; 0 = park in IDLE at an instruction boundary.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  instruction memory has instr_in valid this cycle.
- instr_in  in  32  fetched instruction word.
- ir  out  32  latched instruction register; feeds the decoder.
- regwr_dec  in  1  decoder RegWr for the current ir.
- memwr_dec  in  1  decoder MemWr for the current ir.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable (store).
- dmem_ready  in  1  data access complete; load data valid.
- rf_we  out  1  qualified register-file write strobe.
- pc_we  out  1  PC update strobe (loads next PC from the branch unit).
- ir_we  out  1  IR load strobe (debug visibility).
- halted  out  1  sticky: ECALL/EBREAK or illegal opcode reached.
- illegal  out  1  sticky: halt cause was an illegal opcode.
- state  out  3  current FSM state (debug).

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Value 7 is unused and recovers to IDLE on the next clock.
- Reset (rst_n low, async):
  - state=IDLE, ir=RESET_IR, halted=0, illegal=0.
  - Every strobe (imem_req, dmem_req, dmem_we, rf_we, pc_we, ir_we) is 0.
- Outputs are Moore, decoded from the registered state, except dmem_we and rf_we, which also AND in the decoder inputs.
- Transitions:
  - IDLE: go to FETCH if run=1, else stay.
  - FETCH:
    - imem_req=1 and is held until imem_ready is sampled 1.
    - In the ready cycle, ir_we=1, ir<=instr_in, then go to DECODE.
    - imem_ready while not in FETCH is ignored.
  - DECODE: one cycle. Classify ir[6:0]:
    - Legal opcodes: 0110111, 0010111, 0110011, 0010011, 1101111, 1100111, 1100011, 0000011, 0100011, 0001111 (FENCE = NOP), 1110011.
    - 1110011 (ECALL/EBREAK): go to HALT, set halted=1.
    - Any other opcode not in the list: go to HALT, set halted=1 and illegal=1.
    - Otherwise go to EXEC.
  - EXEC: one cycle, no strobes (ALU settles). If opcode is 0000011 or 0100011, go to MEM; else go to WB.
  - MEM:
    - dmem_req=1 and dmem_we=memwr_dec, held until dmem_ready is sampled 1; then go to WB.
    - Load data is captured by the datapath in the dmem_ready cycle.
  - WB:
    - rf_we=regwr_dec. Stores and branches therefore do not write; x0 protection belongs to the register file.
    - pc_we=1 for exactly one cycle.
    - Next state is FETCH if run=1, else IDLE.
  - HALT: terminal. No strobes, pc_we=0, PC holds the faulting instruction's address. Only rst_n exits.
- Guarantees and latencies:
  - Exactly one pc_we pulse and at most one rf_we pulse per retired instruction.
  - dmem_req is never asserted outside MEM.
  - Minimum latency with zero-wait memories: ALU/branch/jump = 4 cycles; load/store = 5 cycles. Each memory wait cycle adds one.
- Boundary cases:
  - run dropping mid-instruction: the instruction completes; the FSM parks only at WB→IDLE.
  - Reset asserted mid-handshake: imem_req/dmem_req drop immediately (async). Any in-flight memory response is ignored after reset.
  - imem_ready and run=0 in the same cycle: the fetch still completes.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: adds output ports cycle_cnt [XLEN] and instret_cnt [XLEN], both reset to 0.
  - cycle_cnt increments every cycle the state is not IDLE or HALT.
  - instret_cnt increments on each WB cycle.
  - Both wrap from 32'hFFFFFFFF to 0.
- Undefined: ports and logic are absent. All other behaviour is identical.

Test Plan:
- Reset then run=1, zero-wait memories, ir=ADDI (32'h00500093) → states 0,1,2,3,5,1. rf_we=1 and pc_we=1 in the same single cycle, 4 cycles per instruction.
- LW (32'h0000A103) with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0, then WB with rf_we=1; 8 cycles total.
- SW (32'h0020A223), memwr_dec=1, regwr_dec=0 → dmem_we=1 throughout MEM, rf_we=0 in WB, pc_we=1.
- Illegal opcode 32'h0000007F → HALT after DECODE, halted=1, illegal=1, no further imem_req for 20 cycles. ECALL 32'h00000073 → halted=1, illegal=0.
- run=0 asserted during EXEC of a BEQ → instruction completes (pc_we pulse), FSM parks in IDLE. Re-asserting run resumes fetch the next cycle.
- rst_n pulsed low while in MEM with dmem_req=1 → dmem_req=0 immediately, state=IDLE, ir=32'h00000013. With SEQ_PERF_CNT_EN, both counters read 0.
